// File: rtl/spi_controller_pkg.sv
// spi_controller_pkg: shared constants, FSM state type and register map for the
// 16-bit SPI register-write link (controller side).
//   FRAME_BITS/ADDR_W/DATA_W : frame geometry {rw, addr[6:0], data[7:0]}
//   state_t                  : controller FSM states
//   REG_*                    : peripheral register addresses
// Optional feature macro: SPI_CTRL_READ_EN (see spi_controller.sv).
package spi_controller_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // MSB is transmitted first: rw, then addr, then data.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic rw,
                                                          input logic [ADDR_W-1:0] addr,
                                                          input logic [DATA_W-1:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if: request handshake plus SPI pins of the controller.
//   master modport : request source (harness / on-chip master)
//   slave modport  : spi_controller itself
//   req_valid/req_ready/req_addr/req_data : request handshake
//   cs/sclk/copi  : SPI pins driven by the controller
//   busy/done     : transfer status
// With SPI_CTRL_READ_EN defined: req_rw, cipo, rd_data, rd_valid are added.
interface spi_controller_if;
    import spi_controller_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              cs;
    logic              sclk;
    logic              copi;
    logic              busy;
    logic              done;
`ifdef SPI_CTRL_READ_EN
    logic              req_rw;
    logic              cipo;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
`endif

    modport master (
        output req_valid, req_addr, req_data,
`ifdef SPI_CTRL_READ_EN
        output req_rw, cipo,
        input  rd_data, rd_valid,
`endif
        input  req_ready, cs, sclk, copi, busy, done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
`ifdef SPI_CTRL_READ_EN
        input  req_rw, cipo,
        output rd_data, rd_valid,
`endif
        output req_ready, cs, sclk, copi, busy, done
    );

endinterface

// File: rtl/spi_sclk_divider.sv
// spi_sclk_divider: sclk phase timer, active only while the controller shifts.
//   clk, rst      : system clock, async active-high reset
//   i_en          : count enable (SHIFT state); counter and phase clear when low
//   o_rise_tick   : last cycle of a low phase (sclk goes high next cycle)
//   o_fall_tick   : last cycle of a high phase (sclk goes low next cycle)
module spi_sclk_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int unsigned     CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;   // 0 = low half, 1 = high half
    logic             w_wrap;

    assign w_wrap      = i_en && (r_cnt == CNT_MAX);
    assign o_rise_tick = w_wrap && !r_phase;
    assign o_fall_tick = w_wrap && r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 controller shifting one 16-bit {rw, addr, data} frame MSB first.
//   clk, rst : system clock, async active-high reset
//   bus      : spi_controller_if.slave (request handshake, cs/sclk/copi, busy/done)
// Optional feature macro: SPI_CTRL_READ_EN -- takes rw from req_rw, samples cipo on data
// bits and returns rd_data/rd_valid. Without it every frame is a write (bit15 = 1).
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input logic             clk,
    input logic             rst,
    spi_controller_if.slave bus
);

    localparam int unsigned      WAIT_MAX   = max3(CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int unsigned      WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] SETUP_LOAD = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] HOLD_LOAD  = WAIT_W'(CS_HOLD - 1);
    localparam logic [WAIT_W-1:0] IDLE_LOAD  = WAIT_W'(CS_IDLE - 1);

    state_t                r_state;
    logic [WAIT_W-1:0]     r_wait;
    logic [3:0]            r_bit;
    logic [FRAME_BITS-1:0] r_shift;   // MSB drives copi directly
    logic                  r_ready;
    logic                  r_cs;
    logic                  r_sclk;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_rw;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_rise;
    logic                  w_fall;

`ifdef SPI_CTRL_READ_EN
    logic                  r_rw;
    logic [DATA_W-1:0]     r_rd_shift;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_rd_valid;

    assign w_rw         = bus.req_rw;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`else
    assign w_rw = 1'b1;
`endif

    assign w_accept = bus.req_valid && r_ready;
    assign w_frame  = build_frame(w_rw, bus.req_addr, bus.req_data);

    assign bus.req_ready = r_ready;
    assign bus.cs        = r_cs;
    assign bus.sclk      = r_sclk;
    assign bus.copi      = r_shift[FRAME_BITS-1];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    spi_sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_en        (r_state == StShift),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_wait  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ready <= 1'b0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            r_rw       <= 1'b1;
            r_rd_shift <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            r_rd_valid <= 1'b0;
`endif
            unique case (r_state)
                StIdle: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_state <= StSetup;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b0;
                        r_shift <= w_frame;
                        r_bit   <= 4'd15;
                        r_wait  <= SETUP_LOAD;
`ifdef SPI_CTRL_READ_EN
                        r_rw    <= w_rw;
`endif
                    end
                end
                StSetup: begin
                    if (r_wait == '0) r_state <= StShift;
                    else              r_wait  <= r_wait - 1'b1;
                end
                StShift: begin
                    if (w_rise) r_sclk <= 1'b1;
                    if (w_fall) begin
                        r_sclk <= 1'b0;
`ifdef SPI_CTRL_READ_EN
                        // Data bits occupy bit counter values 7..0.
                        if (r_bit <= 4'd7) r_rd_shift <= {r_rd_shift[DATA_W-2:0], bus.cipo};
`endif
                        if (r_bit == 4'd0) begin
                            // Last bit stays on copi through HOLD.
                            r_state <= StHold;
                            r_wait  <= HOLD_LOAD;
                        end else begin
                            r_bit   <= r_bit - 1'b1;
                            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (r_wait == '0) begin
                        r_state <= StGap;
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        r_wait  <= IDLE_LOAD;
`ifdef SPI_CTRL_READ_EN
                        if (!r_rw) begin
                            r_rd_data  <= r_rd_shift;
                            r_rd_valid <= 1'b1;
                        end
`endif
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                StGap: begin
                    if (r_wait == '0) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
